// File: rtl/led_count_allocator_if.sv
// Bundles the allocation request (amplitudes + start) and the LED-count result
// handed to the downstream LED serial driver.
interface led_count_allocator_if #(
  parameter int unsigned LEDS    = 50,
  parameter int unsigned BIN_QTY = 12,
  parameter int unsigned W       = 6,
  parameter int unsigned D       = 10
);
  localparam int unsigned QW = $clog2(LEDS);

  logic                              start;
  logic [BIN_QTY-1:0][W+D-1:0]       noteAmplitudes;
  logic [BIN_QTY-1:0][QW-1:0]        LEDCounts;
  logic                              data_v;
  logic                              busy;

  modport master (
    output start, noteAmplitudes,
    input  LEDCounts, data_v, busy
  );

  modport slave (
    input  start, noteAmplitudes,
    output LEDCounts, data_v, busy
  );
endinterface

// File: rtl/led_count_allocator.sv
// Splits LEDS strip LEDs across BIN_QTY bins in proportion to amplitude, using a
// bit-serial restoring divider; the leftover from flooring goes to the loudest bin.
module led_count_allocator #(
  parameter int unsigned LEDS    = 50,
  parameter int unsigned BIN_QTY = 12,
  parameter int unsigned W       = 6,
  parameter int unsigned D       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  led_count_allocator_if.slave   bus
);

  localparam int unsigned QW = $clog2(LEDS);
  localparam int unsigned AW = W + D;
  localparam int unsigned SW = AW + $clog2(BIN_QTY);
  localparam int unsigned NW = AW + QW;
  localparam int unsigned IW = $clog2(BIN_QTY);
  localparam int unsigned BW = $clog2(QW);

  localparam logic [IW-1:0] LAST_BIN = IW'(BIN_QTY - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(QW - 1);

  generate
    if ((LEDS & (LEDS - 1)) == 0) begin : g_leds_not_pow2
      $error("led_count_allocator: LEDS must not be a power of two");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SUM,
    S_DIV,
    S_FIX,
    S_VALID
  } state_t;

  state_t                      state_q, state_d;
  logic [BIN_QTY-1:0][AW-1:0]  amp_q, amp_d;
  logic [SW-1:0]               sum_q, sum_d;
  logic [AW-1:0]               max_val_q, max_val_d;
  logic [IW-1:0]               max_idx_q, max_idx_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [BW-1:0]               bit_q, bit_d;
  logic [SW-1:0]               rem_q, rem_d;
  logic [QW-1:0]               quo_q, quo_d;
  logic [BIN_QTY-1:0][QW-1:0]  cnt_q, cnt_d;
  logic [QW:0]                 total_q, total_d;
  logic [BIN_QTY-1:0][QW-1:0]  led_counts_q, led_counts_d;
  logic                        data_v_q, data_v_d;
  logic                        busy_q, busy_d;

  logic [NW-1:0]               num;
  logic [QW-1:0]               num_lo;
  logic [SW-1:0]               rem_in;
  logic [QW-1:0]               quo_in;
  logic [QW-1:0]               quo_next;
  logic [SW:0]                 trial;
  logic                        ge;

  always_comb begin
    state_d      = state_q;
    amp_d        = amp_q;
    sum_d        = sum_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    idx_d        = idx_q;
    bit_d        = bit_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    led_counts_d = led_counts_q;

    num      = NW'(amp_q[idx_q]) * NW'(LEDS);
    num_lo   = num[QW-1:0];
    rem_in   = '0;
    quo_in   = '0;
    quo_next = '0;
    trial    = '0;
    ge       = 1'b0;

    case (state_q)
      S_IDLE, S_VALID: begin
        if (bus.start) begin
          amp_d     = bus.noteAmplitudes;
          sum_d     = '0;
          max_val_d = '0;
          max_idx_d = '0;
          idx_d     = '0;
          bit_d     = '0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        total_d = '0;
        state_d = S_SUM;
      end

      S_SUM: begin
        sum_d = sum_q + SW'(amp_q[idx_q]);
        if (amp_q[idx_q] > max_val_q) begin
          max_val_d = amp_q[idx_q];
          max_idx_d = idx_q;
        end
        if (idx_q == LAST_BIN) begin
          idx_d   = '0;
          bit_d   = '0;
          state_d = (sum_d == '0) ? S_FIX : S_DIV;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DIV: begin
        // First step of each bin seeds the remainder with the numerator's top
        // AW bits; that value is below sum because amp <= sum and LEDS < 2^QW.
        rem_in   = (bit_q == '0) ? SW'(num[NW-1:QW]) : rem_q;
        quo_in   = (bit_q == '0) ? '0 : quo_q;
        trial    = {rem_in, num_lo[LAST_BIT - bit_q]};
        ge       = (trial >= {1'b0, sum_q});
        rem_d    = ge ? SW'(trial - {1'b0, sum_q}) : trial[SW-1:0];
        quo_next = {quo_in[QW-2:0], ge};
        quo_d    = quo_next;
        if (bit_q == LAST_BIT) begin
          bit_d        = '0;
          cnt_d[idx_q] = quo_next;
          total_d      = total_q + (QW+1)'(quo_next);
          if (idx_q == LAST_BIN) begin
            idx_d   = '0;
            state_d = S_FIX;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end

      S_FIX: begin
        if (sum_q == '0) begin
          led_counts_d = '0;
        end else begin
          led_counts_d            = cnt_q;
          led_counts_d[max_idx_q] = cnt_q[max_idx_q] + QW'((QW+1)'(LEDS) - total_q);
        end
        state_d = S_VALID;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_LOAD) || (state_d == S_SUM) ||
               (state_d == S_DIV)  || (state_d == S_FIX);
    data_v_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      amp_q        <= '0;
      sum_q        <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      idx_q        <= '0;
      bit_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      total_q      <= '0;
      led_counts_q <= '0;
      data_v_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      amp_q        <= amp_d;
      sum_q        <= sum_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      idx_q        <= idx_d;
      bit_q        <= bit_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      led_counts_q <= led_counts_d;
      data_v_q     <= data_v_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.LEDCounts = led_counts_q;
  assign bus.data_v    = data_v_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_led_count_allocator.sv
// Directed and random allocations checked against an integer-arithmetic model
// of proportional LED sharing with leftover assigned to the loudest bin.
module tb_led_count_allocator;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int W       = 6;
  localparam int D       = 10;
  localparam int QW      = $clog2(LEDS);
  localparam int AW      = W + D;
  localparam int LAT_NZ  = 2 + BIN_QTY + BIN_QTY * QW + 1;
  localparam int LAT_Z   = 2 + BIN_QTY + 1;

  typedef logic [BIN_QTY-1:0][AW-1:0] amp_vec_t;
  typedef logic [BIN_QTY-1:0][QW-1:0] cnt_vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  led_count_allocator_if #(.LEDS(LEDS), .BIN_QTY(BIN_QTY), .W(W), .D(D)) bus ();

  led_count_allocator #(.LEDS(LEDS), .BIN_QTY(BIN_QTY), .W(W), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint amp_sum(input amp_vec_t v);
    longint s = 0;
    for (int i = 0; i < BIN_QTY; i++) s += longint'(v[i]);
    return s;
  endfunction

  // Proportional share: floor(amp*LEDS/sum) each, remainder to first max bin.
  function automatic cnt_vec_t model_counts(input amp_vec_t v);
    longint   s, tot, c[BIN_QTY];
    int       mx;
    cnt_vec_t r;
    r = '0;
    s = amp_sum(v);
    if (s == 0) return r;
    tot = 0;
    mx  = 0;
    for (int i = 0; i < BIN_QTY; i++) begin
      c[i] = (longint'(v[i]) * LEDS) / s;
      tot += c[i];
      if (v[i] > v[mx]) mx = i;
    end
    c[mx] += LEDS - tot;
    for (int i = 0; i < BIN_QTY; i++) r[i] = c[i][QW-1:0];
    return r;
  endfunction

  function automatic int count_total(input cnt_vec_t c);
    int t = 0;
    for (int i = 0; i < BIN_QTY; i++) t += int'(c[i]);
    return t;
  endfunction

  // Called at a negedge: accepts at the next posedge, then samples one cycle on.
  task automatic launch(input amp_vec_t v);
    bus.noteAmplitudes = v;
    bus.start          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 1;
    chk("busy_rise", bus.busy, 1'b1);
    chk("dv_drop", bus.data_v, 1'b0);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_result(input amp_vec_t v, input string tag);
    cnt_vec_t exp_c;
    int       lat;
    while (bus.data_v !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    exp_c = model_counts(v);
    lat   = (amp_sum(v) == 0) ? LAT_Z : LAT_NZ;
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_counts"}, bus.LEDCounts, exp_c);
    chk({tag, "_busy_low"}, bus.busy, 1'b0);
    if (amp_sum(v) != 0) chk({tag, "_total"}, count_total(bus.LEDCounts), LEDS);
  endtask

  amp_vec_t v_tie, v_b5, v_zero, v_mix, v_rnd;
  cnt_vec_t e, held;

  initial begin
    v_tie = '0; v_tie[0] = 16'd1024; v_tie[1] = 16'd1024; v_tie[2] = 16'd1024;
    v_b5  = '0; v_b5[5] = 16'd300;
    v_zero = '0;
    v_mix = '0; v_mix[0] = 16'd1024; v_mix[3] = 16'd1024; v_mix[7] = 16'd2048;

    // Reset held with start asserted
    rst = 1'b0;
    bus.start = 1'b1;
    bus.noteAmplitudes = v_tie;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_counts", bus.LEDCounts, '0);
    chk("rst_dv", bus.data_v, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;

    // Three-way tie: first start after reset is accepted on the first edge
    launch(v_tie);
    wait_result(v_tie, "tie");
    e = '0; e[0] = 6'd18; e[1] = 6'd16; e[2] = 6'd16;
    chk("tie_const", bus.LEDCounts, e);

    held = bus.LEDCounts;
    repeat (3) begin
      @(negedge clk);
      chk("valid_hold_dv", bus.data_v, 1'b1);
      chk("valid_hold_cnt", bus.LEDCounts, held);
    end

    // Single bin; previous result must stay visible during computation
    launch(v_b5);
    chk("cnt_stable_busy", bus.LEDCounts, held);
    step_to(60);
    chk("cnt_stable_mid", bus.LEDCounts, held);
    wait_result(v_b5, "bin5");
    e = '0; e[5] = 6'd50;
    chk("bin5_const", bus.LEDCounts, e);

    // All-zero amplitudes take the short path
    launch(v_zero);
    wait_result(v_zero, "zero");

    // Ignored start pulse while busy
    launch(v_mix);
    step_to(40);
    v_rnd = '0;
    for (int i = 0; i < BIN_QTY; i++) v_rnd[i] = AW'($urandom_range(1, 65535));
    bus.noteAmplitudes = v_rnd;
    bus.start = 1'b1;
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    chk("ignored_start_busy", bus.busy, 1'b1);
    wait_result(v_mix, "mix");
    e = '0; e[0] = 6'd12; e[3] = 6'd12; e[7] = 6'd26;
    chk("mix_const", bus.LEDCounts, e);
    repeat (5) @(negedge clk);
    chk("mix_dv_held", bus.data_v, 1'b1);

    // Random vectors, re-triggered straight from VALID
    for (int t = 0; t < 8; t++) begin
      v_rnd = '0;
      for (int i = 0; i < BIN_QTY; i++)
        v_rnd[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 65535));
      if (t == 7) begin
        v_rnd = '0;
        v_rnd[$urandom_range(0, BIN_QTY-1)] = AW'($urandom_range(1, 65535));
      end
      launch(v_rnd);
      wait_result(v_rnd, "rand");
    end

    // Reset during DIV
    launch(v_mix);
    step_to(50);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_counts", bus.LEDCounts, '0);
    chk("midrst_dv", bus.data_v, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    launch(v_b5);
    wait_result(v_b5, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_count_allocator.md
# led_count_allocator

Converts per-bin note amplitudes into per-bin LED counts that sum exactly to `LEDS`. It sits directly upstream of the LED serial driver and produces the `LEDCounts` vector and the `start` level that the driver consumes. Each bin gets a share of the strip proportional to its amplitude. Division is serial, one quotient bit per cycle, so the block uses no wide combinational divider.

## Interface
- `LEDS`, 50: LEDs on the strip. Must not be a power of two; an elaboration-time assertion enforces this.
- `BIN_QTY`, 12: number of note bins.
- `W`, 6: integer bits of an amplitude.
- `D`, 10: fractional bits of an amplitude.
- `clk`  in  1: single clock. All logic is on `posedge clk`.
- `rst`  in  1: synchronous, active-low reset. `rst == 0` at a rising edge resets the block.
- `start`  in  1: request a new allocation. Sampled only in IDLE or VALID.
- `noteAmplitudes`  in  [BIN_QTY-1:0][W+D-1:0]: unsigned fixed-point amplitudes. Sampled on the cycle `start` is accepted.
- `LEDCounts`  out  [BIN_QTY-1:0][$clog2(LEDS)-1:0]: per-bin LED counts. Registered.
- `data_v`  out  1: `LEDCounts` is valid. This is a level signal and connects to the driver's `start`.
- `busy`  out  1: an allocation is in progress.

## Operation
- Definitions:
  - QW = $clog2(LEDS).
  - Sum register width = W+D+$clog2(BIN_QTY).
  - Numerator width = W+D+QW.
- State machine: IDLE, LOAD, SUM, DIV, FIX, VALID.
- IDLE / VALID:
  - `start` = 1 registers `noteAmplitudes`, clears the sum, the max tracker and the bin index, then goes to LOAD.
  - `data_v` is 1 in VALID and 0 in IDLE.
- LOAD: one cycle that clears the accumulated-count register, then goes to SUM.
- SUM: BIN_QTY cycles, one bin per cycle.
  - sum += amp[i].
  - Track the index of the maximum amplitude. Use strict `>` so ties keep the lowest index.
  - After bin BIN_QTY-1: if sum == 0, go to FIX; otherwise go to DIV.
- DIV: QW cycles per bin, bins taken in index order.
  - Restoring division: cnt[i] = floor(amp[i]*LEDS / sum), computed MSB first, one bit per cycle.
  - Quotient ≤ LEDS < 2^QW, so the result never overflows QW bits.
  - Keep a running total of the counts (QW+1 bits). After the last bin, go to FIX.
- FIX (1 cycle):
  - If sum ≠ 0: cnt[max_idx] += LEDS − total. Leftover lies in 0..BIN_QTY−1 and the result never exceeds LEDS.
  - If sum == 0: all counts are 0.
  - Copy the internal counts into `LEDCounts`. Go to VALID.
- Guarantees:
  - When sum ≠ 0, the counts sum exactly to `LEDS`.
  - A bin with zero amplitude receives 0 unless it is max_idx, which requires all amplitudes to be zero, and in that case every count is 0.
- `LEDCounts` changes only in FIX. It holds stable through VALID, the next computation, and IDLE.
- `start` while `busy` is ignored; nothing is queued.
- Reset, including mid-computation:
  - State → IDLE.
  - `LEDCounts` all 0, `data_v` = 0, `busy` = 0.
  - Sum, index and divider registers are cleared.

## Timing
- Accept edge = the rising edge at which `start` = 1 is sampled in IDLE or VALID.
- `busy`:
  - Rises 1 cycle after the accept edge.
  - Stays high through LOAD, SUM, DIV and FIX.
  - Drops when VALID is entered.
- `data_v` drops 1 cycle after the accept edge, so VALID→LOAD deasserts it.
- Latency from the accept edge to `data_v` = 1, with the new `LEDCounts` visible on the same cycle:
  - sum ≠ 0: L = 2 + BIN_QTY + BIN_QTY·QW + 1 cycles. Defaults: 2 + 12 + 72 + 1 = 87.
  - sum == 0: L = 2 + BIN_QTY + 1 = 15 cycles.
- Back-to-back: `start` held high in VALID re-triggers immediately, and `data_v` is low for exactly L cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with `start` = 1.
  - `LEDCounts` = all 0, `data_v` = 0, `busy` = 0.
  - After reset is released, a start is accepted on the first edge.
- Bins 0, 1, 2 = 1024 (1.0), others 0:
  - Floors are 16, 16, 16; the tie resolves to bin 0.
  - `LEDCounts` = {18, 16, 16, 0, …}, summing to 50.
  - `data_v` rises exactly 87 cycles after the accept edge.
- Only bin 5 = 300: `LEDCounts[5]` = 50, all others 0, latency 87.
- All amplitudes 0: `LEDCounts` all 0, `data_v` high after 15 cycles.
- Bins 0 and 3 = 1024, bin 7 = 2048, others 0:
  - `LEDCounts[0]` = 12, `LEDCounts[3]` = 12, `LEDCounts[7]` = 26 (sum 50).
  - Re-pulse `start` at cycle 40 of the computation: it is ignored, `busy` stays 1, and the result is unchanged.
  - `data_v` stays high until the next accepted start, then falls on the next cycle.
- Drive `rst` = 0 during DIV (cycle 50):
  - Next cycle: IDLE, `LEDCounts` = 0, `data_v` = 0.
  - A fresh start with the bin-5 vector then yields 50 in bin 5 after 87 cycles.
